// File: rtl/timer_dev_pkg.sv
// rtl/timer_dev_pkg.sv - shared constants and types for the countdown timer
package timer_dev_pkg;

  localparam logic [31:0] DEFAULT_BASE = 32'h0000_7F00;

  localparam logic [31:0] OFF_CTRL   = 32'h0;
  localparam logic [31:0] OFF_PRESET = 32'h4;
  localparam logic [31:0] OFF_COUNT  = 32'h8;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_IM_BIT   = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_CNT  = 2'b10,
    ST_INT  = 2'b11
  } state_e;

endpackage

// File: rtl/timer_dev_if.sv
// rtl/timer_dev_if.sv - processor-bridge bus bundle for one timer instance
interface timer_dev_if;
  logic [29:0] Addr;
  logic [31:0] WD;
  logic        We;
  logic [31:0] RD;
  logic        IRQ;

  modport master (output Addr, WD, We, input RD, IRQ);
  modport slave  (input Addr, WD, We, output RD, IRQ);
endinterface

// File: rtl/timer_dev_core.sv
// rtl/timer_dev_core.sv - countdown state machine owning COUNT and the pending flag
module timer_core
  import timer_dev_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        en_i,
  input  logic [1:0]  mode_i,
  input  logic [31:0] preset_i,
  input  logic        ctrl_wr_i,
  output logic [31:0] count_o,
  output logic        pend_o,
  output logic        en_clr_o
);

  state_e      state_q, state_d;
  logic [31:0] count_q, count_d;
  logic        pend_q, pend_d;
  logic        pend_set, pend_clr;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      count_q <= 32'h0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    pend_set = 1'b0;
    pend_clr = 1'b0;
    en_clr_o = 1'b0;
    case (state_q)
      ST_IDLE: if (en_i) state_d = ST_LOAD;
      ST_LOAD: begin
        count_d = preset_i;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!en_i) begin
          state_d = ST_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          // A preset of 0 lands here too, so it expires like a preset of 1
          count_d  = 32'h0;
          pend_set = 1'b1;
          state_d  = ST_INT;
        end
      end
      ST_INT: begin
        if (mode_i == MODE_RELOAD) begin
          pend_clr = 1'b1;
          state_d  = ST_LOAD;
        end else begin
          en_clr_o = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Expiry beats a simultaneous CTRL write so the interrupt is never lost
  always_comb begin
    pend_d = pend_q;
    if (ctrl_wr_i || pend_clr) pend_d = 1'b0;
    if (pend_set)              pend_d = 1'b1;
  end

  assign count_o = count_q;
  assign pend_o  = pend_q;

endmodule

// File: rtl/timer_dev.sv
// rtl/timer_dev.sv - memory-mapped countdown timer: bus decode, CTRL/PRESET registers, read mux
module timer_dev
  import timer_dev_pkg::*;
#(
  parameter logic [31:0] BASE = DEFAULT_BASE
) (
  input  logic        Clk,
  input  logic        Reset,
  timer_dev_if.slave  bus
);

  logic        en_q, en_d;
  logic [1:0]  mode_q, mode_d;
  logic        im_q, im_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count;
  logic        pend, en_clr;
  logic [31:0] byte_addr;
  logic        sel_ctrl, sel_preset, sel_count;
  logic        ctrl_wr, preset_wr;

  assign byte_addr  = {bus.Addr, 2'b00};
  assign sel_ctrl   = (byte_addr == BASE + OFF_CTRL);
  assign sel_preset = (byte_addr == BASE + OFF_PRESET);
  assign sel_count  = (byte_addr == BASE + OFF_COUNT);
  assign ctrl_wr    = bus.We & sel_ctrl;
  assign preset_wr  = bus.We & sel_preset;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      en_q     <= 1'b0;
      mode_q   <= MODE_ONESHOT;
      im_q     <= 1'b0;
      preset_q <= 32'h0;
    end else begin
      en_q     <= en_d;
      mode_q   <= mode_d;
      im_q     <= im_d;
      preset_q <= preset_d;
    end
  end

  // A software CTRL write overrides the one-shot auto-disable on the same edge
  always_comb begin
    en_d     = en_q;
    mode_d   = mode_q;
    im_d     = im_q;
    preset_d = preset_q;
    if (ctrl_wr) begin
      en_d   = bus.WD[CTRL_EN_BIT];
      mode_d = bus.WD[CTRL_MODE_LSB +: 2];
      im_d   = bus.WD[CTRL_IM_BIT];
    end else if (en_clr) begin
      en_d = 1'b0;
    end
    if (preset_wr) preset_d = bus.WD;
  end

  timer_core u_core (
    .Clk       (Clk),
    .Reset     (Reset),
    .en_i      (en_q),
    .mode_i    (mode_q),
    .preset_i  (preset_q),
    .ctrl_wr_i (ctrl_wr),
    .count_o   (count),
    .pend_o    (pend),
    .en_clr_o  (en_clr)
  );

  always_comb begin
    bus.RD = 32'h0;
    if (sel_ctrl)   bus.RD = {28'h0, im_q, mode_q, en_q};
    if (sel_preset) bus.RD = preset_q;
    if (sel_count)  bus.RD = count;
  end

  assign bus.IRQ = pend & im_q;

endmodule

// File: tb/tb_timer_dev.sv
// tb/tb_timer_dev.sv - directed self-checking bench for timer_dev
module tb_timer_dev;
  import timer_dev_pkg::*;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  always #5 Clk = ~Clk;

  timer_dev_if bus ();

  timer_dev #(.BASE(DEFAULT_BASE)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  localparam logic [29:0] A_CTRL   = 30'h1FC0;
  localparam logic [29:0] A_PRESET = 30'h1FC1;
  localparam logic [29:0] A_COUNT  = 30'h1FC2;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [29:0] a, input logic [31:0] d);
    @(negedge Clk);
    bus.Addr = a;
    bus.WD   = d;
    bus.We   = 1'b1;
    @(posedge Clk);
    #1;
    bus.We = 1'b0;
  endtask

  task automatic check_rd(input string tag, input logic [29:0] a, input logic [31:0] exp);
    bus.Addr = a;
    #1;
    check(tag, bus.RD, exp);
  endtask

  task automatic check_irq(input string tag, input logic exp);
    check(tag, {31'h0, bus.IRQ}, {31'h0, exp});
  endtask

  initial begin
    logic [31:0] exp_cnt;
    bus.Addr = 30'h0;
    bus.WD   = 32'h0;
    bus.We   = 1'b0;
    #2;
    check_rd("rst_ctrl", A_CTRL, 32'h0);
    check_rd("rst_preset", A_PRESET, 32'h0);
    check_rd("rst_count", A_COUNT, 32'h0);
    check_irq("rst_irq", 1'b0);
    @(negedge Clk);
    Reset = 1'b1;

    // reset asserted mid-count
    wr(A_PRESET, 32'd7);
    wr(A_CTRL, 32'h9);
    repeat (4) @(posedge Clk);
    #1;
    check_rd("pre_rst_count", A_COUNT, 32'd5);
    Reset = 1'b0;
    #1;
    check_rd("midrst_count", A_COUNT, 32'h0);
    check_rd("midrst_ctrl", A_CTRL, 32'h0);
    check_rd("midrst_preset", A_PRESET, 32'h0);
    check_irq("midrst_irq", 1'b0);
    @(negedge Clk);
    Reset = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    check_rd("postrst_count", A_COUNT, 32'h0);

    // one-shot, PRESET=3: IRQ after write edge + 5
    wr(A_PRESET, 32'd3);
    wr(A_CTRL, 32'h9);
    for (int k = 1; k <= 6; k++) begin
      @(posedge Clk);
      #1;
      check_irq($sformatf("os_irq_k%0d", k), k >= 5);
    end
    check_rd("os_count", A_COUNT, 32'h0);
    check_rd("os_ctrl", A_CTRL, 32'h8);
    wr(A_CTRL, 32'h0);
    check_irq("os_irq_clr", 1'b0);

    // PRESET=0 behaves as 1
    wr(A_PRESET, 32'd0);
    wr(A_CTRL, 32'h9);
    for (int k = 1; k <= 3; k++) begin
      @(posedge Clk);
      #1;
      check_irq($sformatf("p0_irq_k%0d", k), k == 3);
    end
    wr(A_CTRL, 32'h0);
    check_irq("p0_irq_clr", 1'b0);

    // auto-reload, PRESET=2: period 4
    wr(A_PRESET, 32'd2);
    wr(A_CTRL, 32'hB);
    bus.Addr = A_COUNT;
    for (int k = 1; k <= 12; k++) begin
      @(posedge Clk);
      #1;
      if (k == 1) exp_cnt = 32'd0;
      else case ((k - 2) % 4)
        0:       exp_cnt = 32'd2;
        1:       exp_cnt = 32'd1;
        default: exp_cnt = 32'd0;
      endcase
      check($sformatf("ar_count_k%0d", k), bus.RD, exp_cnt);
      check_irq($sformatf("ar_irq_k%0d", k), (k % 4) == 0);
    end
    wr(A_CTRL, 32'h0);
    repeat (3) @(posedge Clk);
    #1;
    check_irq("ar_stop_irq", 1'b0);

    // disable mid-count, then re-enable
    wr(A_PRESET, 32'd10);
    wr(A_CTRL, 32'h1);
    repeat (4) @(posedge Clk);
    wr(A_CTRL, 32'h0);
    repeat (5) @(posedge Clk);
    #1;
    check_rd("hold_count", A_COUNT, 32'd7);
    check_irq("hold_irq", 1'b0);
    wr(A_CTRL, 32'h1);
    repeat (2) @(posedge Clk);
    #1;
    check_rd("reload_count", A_COUNT, 32'd10);

    // masked expiry, then CTRL write clears pend
    repeat (12) @(posedge Clk);
    #1;
    check_irq("mask_irq", 1'b0);
    check_rd("mask_ctrl", A_CTRL, 32'h0);
    check_rd("mask_count", A_COUNT, 32'h0);
    wr(A_CTRL, 32'h8);
    repeat (2) @(posedge Clk);
    #1;
    check_irq("unmask_irq", 1'b0);
    check_rd("unmask_ctrl", A_CTRL, 32'h8);

    // read-only COUNT and unmapped offsets
    wr(A_COUNT, 32'h0000_FFFF);
    wr(A_COUNT + 30'd1, 32'h1234_5678);
    check_rd("ro_count", A_COUNT, 32'h0);
    check_rd("rd_off_c", A_COUNT + 30'd1, 32'h0);
    check_rd("rd_off_10", A_COUNT + 30'd2, 32'h0);
    check_rd("rd_below", A_CTRL - 30'd1, 32'h0);
    check_rd("preset_keep", A_PRESET, 32'd10);

    // CTRL write on the INT edge beats one-shot En clear and clears pend
    wr(A_PRESET, 32'd1);
    wr(A_CTRL, 32'h9);
    repeat (3) @(posedge Clk);
    #1;
    check_irq("win_irq_set", 1'b1);
    wr(A_CTRL, 32'h9);
    check_rd("win_ctrl", A_CTRL, 32'h9);
    check_irq("win_irq_clr", 1'b0);
    wr(A_CTRL, 32'h0);
    repeat (3) @(posedge Clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/timer_dev.md
# timer_dev

Memory-mapped countdown timer on the CPU's processor-bridge bus (the PrAddr/PrWD/PrWe/PrRD port driven by the memory stage). Responds to word writes and combinational reads of three registers. Raises a maskable interrupt request when the count expires, in one-shot or auto-reload mode. Sits behind the bridge decoder, one instance per timer.

## Interface
Parameters:
- BASE, 32'h0000_7F00: word-aligned base byte address; decoded window is BASE..BASE+8.

Ports:
- Clk  in  1  system clock; all state changes on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Addr  in  30  word address [31:2] from bridge.
- WD  in  32  write data.
- We  in  1  write enable. Already qualified by the CPU for exceptions and by the bridge for this device's window.
- RD  out  32  combinational read data.
- IRQ  out  1  interrupt request to CP0 hardware-interrupt input.

## Operation
- Registers, by byte offset from BASE:
  - 0x0 CTRL: [0] En, [2:1] Mode, [3] IM (interrupt mask). Bits [31:4] read 0 and ignore writes.
  - 0x4 PRESET: 32-bit reload value. Read/write.
  - 0x8 COUNT: 32-bit current count. Read-only; writes are ignored.
- RD returns the addressed register. Any other offset in the window, or an address outside it, reads 32'h0.
- Mode 00 is one-shot; mode 01 is auto-reload. Modes 10/11 behave as 00.
- State machine, 2-bit encoding:
  - IDLE: if En, go to LOAD.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT: if !En, go to IDLE with COUNT held. Else if COUNT > 1, decrement COUNT. Else set COUNT <= 0, set pend, and go to INT.
  - INT, Mode 00: clear En; go to IDLE.
  - INT, Mode 01: go to LOAD.
- Transitions evaluate register values from before the edge.
- pend behaviour:
  - Mode 00: stays set until any CTRL write.
  - Mode 01: cleared on the edge leaving INT.
- IRQ = pend & IM. It is registered-state-derived with no combinational path from bus inputs.
- Simultaneous events:
  - A CTRL write wins over INT's En clear.
  - A CTRL write and pend set on the same edge: pend is set.
  - A PRESET write during CNT does not disturb COUNT; it takes effect at the next LOAD.
- Reset: CTRL, PRESET, COUNT and pend are 0, state is IDLE. Hence RD (unselected) is 0 and IRQ is 0. Reset asserted mid-count aborts the count immediately.

## Timing
- Write latency: a register updates on the edge where We=1. RD reflects the new value the following cycle.
- From a CTRL write of En=1 at edge E0 with PRESET=N (N≥1):
  - LOAD at E1.
  - COUNT=N after E2.
  - INT entered and IRQ high after edge E0+N+2 (if IM=1).
- PRESET=0 behaves as PRESET=1.
- Auto-reload period is N+2 cycles per interrupt. IRQ in mode 01 is a 1-cycle pulse.
- COUNT never wraps below 0.

## Structure
- Shared header/package holds:
  - register offsets (CTRL/PRESET/COUNT);
  - CTRL bit positions;
  - mode codes;
  - state encodings (IDLE/LOAD/CNT/INT);
  - default BASE.
- One natural sub-module, timer_core: the state machine, COUNT and pend. Inputs En/Mode/PRESET; outputs COUNT, pend and en_clr.
- timer_dev keeps bus decode, CTRL/PRESET registers and the RD mux.

## Test plan
- Reset low mid-count (COUNT=5) -> all registers, RD and IRQ are 0 immediately; state IDLE after release.
- PRESET=3, CTRL=0x9 (En, mode 00, IM) -> IRQ rises 5 cycles after the write edge and stays high. COUNT reads 0, CTRL reads 0x8. Writing CTRL=0 drops IRQ next cycle.
- PRESET=2, CTRL=0xB (auto-reload) -> IRQ 1-cycle pulses every 4 cycles; COUNT sequence 2,1,0,x,2...
- Mid-count CTRL write En=0 at COUNT=7 -> COUNT holds at 7 and IRQ stays 0. Re-enable -> reloads from PRESET, not 7.
- IM=0 with mode 00 expiry -> IRQ stays 0. Then write CTRL=0x8 -> IRQ stays 0, because the CTRL write clears pend.
- Write COUNT=0xFFFF and read offset 0xC / address BASE+0x10 -> COUNT unchanged; both reads return 0.
